// File: rtl/soc_pkg.sv
// ============================================================================
//  Module   : soc_pkg
//  Brief    : Shared constants for the interrupt controller register port and FSM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_pkg;

    localparam logic [2:0] IRQ_PENDING  = 3'd0;
    localparam logic [2:0] IRQ_ENABLE   = 3'd1;
    localparam logic [2:0] IRQ_EDGE     = 3'd2;
    localparam logic [2:0] IRQ_CLAIM    = 3'd3;
    localparam logic [2:0] IRQ_COMPLETE = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        WAIT   = 2'd2
    } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
//  Module   : irq_prio_enc
//  Brief    : Fixed-priority encoder; lowest set index wins, ID = index+1, 0 = none.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 5
) (
    input  logic [N_SRC-1:0] vec,
    output logic [ID_W-1:0]  id
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i + 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module   : irq_ctrl
//  Brief    : Latching, masking, prioritising interrupt controller with
//             claim/complete handshake; source 0 is the timer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id
);

    import soc_pkg::*;

    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_edge_sel;
    logic [N_SRC-1:0] r_in_service;
    logic [31:0]      r_rdata;
    logic             r_irq;
    logic [ID_W-1:0]  r_irq_id;
    irq_state_t       r_state;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_id_hit;
    logic [N_SRC-1:0] w_claim_clr;
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_pending_nx;
    logic [ID_W-1:0]  w_sel_id;
    logic             w_claim;
    logic             w_complete;
    logic [31:0]      w_rd_val;
    irq_state_t       w_state_nx;
    logic             w_irq_nx;
    logic [ID_W-1:0]  w_irq_id_nx;
    logic             w_unused_wdata;

    assign w_unused_wdata = ^wdata;

    assign rdata  = r_rdata;
    assign irq    = r_irq;
    assign irq_id = r_irq_id;

    assign w_rise  = src & ~r_src_q;
    assign w_w1c   = (we && addr == IRQ_PENDING) ? wdata[N_SRC-1:0] : '0;
    assign w_cand  = r_pending & r_enable & ~r_in_service;

    // Only the presented ID may be claimed or completed.
    assign w_claim    = re && (addr == IRQ_CLAIM) && (r_state == ASSERT);
    assign w_complete = we && (addr == IRQ_COMPLETE) && (r_state == WAIT) &&
                        (wdata[ID_W-1:0] == r_irq_id) && (r_irq_id != '0);

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            assign w_id_hit[i] = (r_irq_id == ID_W'(i + 1));
        end
    endgenerate

    assign w_claim_clr = w_claim ? w_id_hit : '0;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .vec (w_cand),
        .id  (w_sel_id)
    );

    // Edge bits: a new rising edge beats a same-cycle W1C or claim clear.
    always_comb begin
        w_pending_nx = r_pending;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_edge_sel[i]) begin
                if (w_rise[i]) begin
                    w_pending_nx[i] = 1'b1;
                end else if (w_w1c[i] || w_claim_clr[i]) begin
                    w_pending_nx[i] = 1'b0;
                end
            end else begin
                w_pending_nx[i] = src[i];
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (addr)
            IRQ_PENDING: w_rd_val = 32'(r_pending);
            IRQ_ENABLE:  w_rd_val = 32'(r_enable);
            IRQ_EDGE:    w_rd_val = 32'(r_edge_sel);
            IRQ_CLAIM:   w_rd_val = (r_state == ASSERT) ? 32'(r_irq_id) : '0;
            default:     w_rd_val = '0;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_irq_nx    = 1'b0;
        w_irq_id_nx = r_irq_id;
        case (r_state)
            IDLE: begin
                w_irq_id_nx = '0;
                if (w_cand != '0) begin
                    w_state_nx  = ASSERT;
                    w_irq_nx    = 1'b1;
                    w_irq_id_nx = w_sel_id;
                end
            end
            ASSERT: begin
                if (w_claim) begin
                    w_state_nx = WAIT;
                end else if (w_cand == '0) begin
                    w_state_nx  = IDLE;
                    w_irq_id_nx = '0;
                end else begin
                    w_irq_nx    = 1'b1;
                    w_irq_id_nx = w_sel_id;
                end
            end
            WAIT: begin
                if (w_complete) begin
                    w_state_nx  = IDLE;
                    w_irq_id_nx = '0;
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_irq_id_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_irq    <= w_irq_nx;
            r_irq_id <= w_irq_id_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_q      <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_edge_sel   <= '0;
            r_in_service <= '0;
            r_rdata      <= '0;
        end else begin
            r_src_q   <= src;
            r_pending <= w_pending_nx;
            if (we && addr == IRQ_ENABLE) begin
                r_enable <= wdata[N_SRC-1:0];
            end
            if (we && addr == IRQ_EDGE) begin
                r_edge_sel <= wdata[N_SRC-1:0];
            end
            // At most one source is ever in service, so complete clears all.
            if (w_complete) begin
                r_in_service <= '0;
            end else if (w_claim) begin
                r_in_service <= w_claim_clr;
            end
            if (re) begin
                r_rdata <= w_rd_val;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module   : tb_irq_ctrl
//  Brief    : Directed vector table plus hand-written sequences for irq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

    import soc_pkg::*;

    localparam int N_SRC = 8;
    localparam int ID_W  = 5;

    typedef struct {
        logic [7:0]  src;
        logic        we;
        logic        re;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        exp_irq;
        logic [4:0]  exp_id;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] src;
    logic [2:0]       addr;
    logic [31:0]      wdata;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic             irq;
    logic [ID_W-1:0]  irq_id;

    int   errors = 0;
    int   checks = 0;
    vec_t vq[$];

    irq_ctrl #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .src    (src),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .re     (re),
        .rdata  (rdata),
        .irq    (irq),
        .irq_id (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] s, input logic w, input logic r,
                        input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        src = s; we = w; re = r; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] s, input logic w, input logic r,
                       input logic [2:0] a, input logic [31:0] d,
                       input logic ei, input logic [4:0] eid,
                       input logic cr, input logic [31:0] erd);
        vq.push_back('{s, w, r, a, d, ei, eid, cr, erd});
    endtask

    task automatic irq_chk(input string nm, input logic ei, input logic [4:0] eid);
        chk({nm, " irq"}, 32'(irq), 32'(ei));
        chk({nm, " irq_id"}, 32'(irq_id), 32'(eid));
    endtask

    initial begin
        rst = 1'b0; src = '0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;

        // Timer edge: pulse at vec 2, irq at vec 3, claim, complete.
        add(8'h00, 1, 0, IRQ_ENABLE,   32'h01, 0, 0, 0, 0);
        add(8'h00, 1, 0, IRQ_EDGE,     32'h01, 0, 0, 0, 0);
        add(8'h01, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 1, 1, 0, 0);
        add(8'h00, 0, 1, IRQ_CLAIM,    32'h00, 0, 1, 1, 32'd1);
        add(8'h00, 0, 1, IRQ_PENDING,  32'h00, 0, 1, 1, 32'h0);
        add(8'h00, 1, 0, IRQ_COMPLETE, 32'd1,  0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        // Priority: src[5] and src[2] together.
        add(8'h00, 1, 0, IRQ_ENABLE,   32'hFF, 0, 0, 0, 0);
        add(8'h00, 1, 0, IRQ_EDGE,     32'hFF, 0, 0, 0, 0);
        add(8'h24, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 1, 3, 0, 0);
        add(8'h00, 0, 1, IRQ_CLAIM,    32'h00, 0, 3, 1, 32'd3);
        add(8'h00, 1, 0, IRQ_COMPLETE, 32'd3,  0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 1, 6, 0, 0);
        add(8'h00, 0, 1, IRQ_CLAIM,    32'h00, 0, 6, 1, 32'd6);
        add(8'h00, 1, 0, IRQ_COMPLETE, 32'd6,  0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        // Masking: pending captured while disabled, then enabled.
        add(8'h00, 1, 0, IRQ_ENABLE,   32'h00, 0, 0, 0, 0);
        add(8'h10, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        add(8'h00, 0, 1, IRQ_PENDING,  32'h00, 0, 0, 1, 32'h10);
        add(8'h00, 1, 0, IRQ_ENABLE,   32'h10, 0, 0, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 1, 5, 0, 0);
        add(8'h00, 0, 1, IRQ_CLAIM,    32'h00, 0, 5, 1, 32'd5);
        add(8'h00, 1, 0, IRQ_COMPLETE, 32'd5,  0, 0, 0, 0);
        // Level mode on src[1].
        add(8'h00, 1, 0, IRQ_ENABLE,   32'hFF, 0, 0, 0, 0);
        add(8'h00, 1, 0, IRQ_EDGE,     32'h00, 0, 0, 0, 0);
        add(8'h02, 0, 0, IRQ_PENDING,  32'h00, 0, 0, 0, 0);
        add(8'h02, 0, 0, IRQ_PENDING,  32'h00, 1, 2, 0, 0);
        add(8'h02, 0, 1, IRQ_CLAIM,    32'h00, 0, 2, 1, 32'd2);
        add(8'h02, 0, 0, IRQ_PENDING,  32'h00, 0, 2, 0, 0);
        add(8'h02, 1, 0, IRQ_COMPLETE, 32'd2,  0, 0, 0, 0);
        add(8'h02, 0, 0, IRQ_PENDING,  32'h00, 1, 2, 0, 0);
        add(8'h00, 0, 0, IRQ_PENDING,  32'h00, 1, 2, 0, 0);
        add(8'h00, 0, 1, IRQ_PENDING,  32'h00, 0, 0, 1, 32'h0);
        add(8'h00, 0, 1, IRQ_CLAIM,    32'h00, 0, 0, 1, 32'h0);

        repeat (3) @(negedge clk);
        #1;
        irq_chk("reset", 1'b0, 5'd0);
        chk("reset rdata", rdata, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].src, vq[i].we, vq[i].re, vq[i].addr, vq[i].wdata);
            irq_chk($sformatf("vec%0d", i), vq[i].exp_irq, vq[i].exp_id);
            if (vq[i].chk_rd) begin
                chk($sformatf("vec%0d rdata", i), rdata, vq[i].exp_rd);
            end
        end

        // Bad complete, arrival during WAIT, W1C withdrawal while asserted.
        step(8'h00, 1, 0, IRQ_EDGE, 32'hFF);
        step(8'h01, 0, 0, IRQ_PENDING, 32'h0);
        step(8'h00, 0, 0, IRQ_PENDING, 32'h0);
        irq_chk("bad_cpl present", 1'b1, 5'd1);
        step(8'h00, 0, 1, IRQ_CLAIM, 32'h0);
        chk("bad_cpl claim rdata", rdata, 32'd1);
        step(8'h00, 1, 0, IRQ_COMPLETE, 32'd2);
        irq_chk("bad_cpl ignored", 1'b0, 5'd1);
        step(8'h08, 0, 0, IRQ_PENDING, 32'h0);
        step(8'h00, 0, 0, IRQ_PENDING, 32'h0);
        irq_chk("bad_cpl held", 1'b0, 5'd1);
        step(8'h00, 1, 0, IRQ_COMPLETE, 32'd1);
        irq_chk("good_cpl", 1'b0, 5'd0);
        step(8'h00, 0, 0, IRQ_PENDING, 32'h0);
        irq_chk("queued src3", 1'b1, 5'd4);
        step(8'h00, 1, 0, IRQ_PENDING, 32'h08);
        irq_chk("w1c same cycle", 1'b1, 5'd4);
        step(8'h00, 0, 0, IRQ_PENDING, 32'h0);
        irq_chk("w1c withdraw", 1'b0, 5'd0);
        step(8'h00, 0, 1, IRQ_PENDING, 32'h0);
        chk("w1c pending rdata", rdata, 32'h0);

        // Asynchronous reset while in WAIT.
        step(8'h01, 0, 0, IRQ_PENDING, 32'h0);
        step(8'h00, 0, 0, IRQ_PENDING, 32'h0);
        step(8'h00, 0, 1, IRQ_CLAIM, 32'h0);
        chk("pre-reset claim rdata", rdata, 32'd1);
        @(negedge clk);
        re = 1'b0;
        #2 rst = 1'b0;
        #1;
        irq_chk("async reset", 1'b0, 5'd0);
        chk("async reset rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(8'h00, 0, 1, IRQ_ENABLE, 32'h0);
        chk("post-reset enable", rdata, 32'h0);
        step(8'h00, 0, 1, IRQ_PENDING, 32'h0);
        chk("post-reset pending", rdata, 32'h0);
        step(8'h00, 0, 1, IRQ_CLAIM, 32'h0);
        chk("post-reset claim", rdata, 32'h0);
        irq_chk("post-reset", 1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller sitting directly downstream of the timer; consumes the timer's `int` output on source 0, plus up to N_SRC-1 other peripheral interrupt lines.
- Latches, masks and prioritises the sources, then raises a single `irq` to the RISC-V core.
- The core uses a claim/complete handshake over a simple word-addressed register port.

Parameters:
- N_SRC, 8, number of interrupt sources (1..31); src[0] is the timer.
- ID_W, 5, width of source ID field; IDs are 1..N_SRC, and 0 means "none".

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- src  in  N_SRC  interrupt request lines, synchronous to clk.
- addr  in  3  register word address.
- wdata  in  32  write data.
- we  in  1  write strobe, single cycle.
- re  in  1  read strobe, single cycle; we and re are never both high.
- rdata  out  32  read data, registered.
- irq  out  1  interrupt request to the core.
- irq_id  out  ID_W  ID of the source currently presented or in service; 0 if none.

Behaviour:

Reset (rst=0): pending, enable, edge_sel, in_service, src_q, rdata, irq and irq_id all clear to 0; FSM goes to IDLE.

Register map (word addresses):
- 0 PENDING: R; W1C, effective for edge-mode bits only.
- 1 ENABLE: RW.
- 2 EDGE_SEL: RW; 1 = rising-edge mode, 0 = level mode.
- 3 CLAIM: R, side-effecting.
- 4 COMPLETE: W, wdata[ID_W-1:0] = ID.
- 5..7 read 0; writes to them are ignored.
- Bits at or above N_SRC read 0.

Pending logic:
- src_q is a registered copy of src.
- Edge mode: pending[i] sets when src[i] & ~src_q[i]. It clears on W1C or on claim of ID i+1.
- If a set and a clear hit the same bit in the same cycle, set wins.
- Level mode: pending[i] <= src[i] every cycle.
- Pending bits are captured regardless of ENABLE.

Candidate selection:
- cand = pending & ENABLE & ~in_service.
- Selection is a fixed priority encoder: lowest index wins.
- sel_id = index+1, or 0 if cand is empty.

FSM (3 states):
- IDLE: irq=0, irq_id=0. If cand != 0, go to ASSERT and register sel_id into irq_id.
  - Latency: an edge on src at cycle T sets pending at T+1 and gives irq=1 at T+2.
- ASSERT: irq=1. irq_id tracks sel_id each cycle, so a higher-priority arrival preempts the presented ID before claim.
  - If cand becomes 0 (disabled or W1C'd before claim), go to IDLE with irq=0.
  - A CLAIM read returns the current irq_id in rdata on the next cycle. It sets in_service[id-1] and clears pending[id-1] (edge mode). It then goes to WAIT with irq=0 and irq_id held.
- WAIT: irq=0.
  - A COMPLETE write whose ID equals irq_id clears in_service and goes to IDLE.
  - A COMPLETE write with a mismatched ID, or ID 0, is ignored.
  - A level source still high after complete re-asserts via IDLE→ASSERT (2 cycles).
- Any state, CLAIM read outside ASSERT: returns 0 with no side effects.
- Only one interrupt is in service at a time; there is no nesting.

Register access:
- rdata is registered: read data is valid the cycle after re and holds until the next read.
- Writes take effect on the next clock edge.
- ENABLE changes affect cand the cycle after the write.

Reset mid-operation: asynchronous return to reset values from any state. Any in-flight claim is lost.

Decomposition:
- Shared package soc_pkg holds the register address constants:
  - IRQ_PENDING=0, IRQ_ENABLE=1, IRQ_EDGE=2, IRQ_CLAIM=3, IRQ_COMPLETE=4.
  - FSM state encodings IDLE / ASSERT / WAIT.
- One natural sub-module: irq_prio_enc (N_SRC-bit vector to ID_W-bit ID, combinational, lowest index wins).

Test Plan:
1. Timer edge: ENABLE=0x01, EDGE_SEL=0x01; pulse src[0] for 1 cycle at T → irq=1 at T+2 with irq_id=1. CLAIM read → rdata=1, irq=0, PENDING=0. COMPLETE write 1 → FSM returns to IDLE.
2. Priority: ENABLE=0xFF, edge mode; pulse src[5] and src[2] in the same cycle → CLAIM returns 3. COMPLETE 3 → irq reasserts 1 cycle later and CLAIM returns 6.
3. Masking: pulse src[4] with ENABLE=0 → irq stays 0 and PENDING reads 0x10. Then write ENABLE=0x10 → irq=1 two cycles after the write.
4. Bad complete: after claiming ID 1, write COMPLETE 2 → in_service unchanged and no new irq. Then write COMPLETE 1 → FSM returns to IDLE.
5. Level mode: EDGE_SEL=0, src[1] held high, claim then complete → irq reasserts with irq_id=2. Drop src[1] → PENDING bit 1 reads 0 next cycle.
6. Async reset: assert rst=0 in WAIT with ENABLE=0xFF → irq, irq_id, ENABLE and PENDING all read 0 immediately after release. A CLAIM read after release returns 0.
